// File: rtl/var_delay_pkg.sv
// Shared helpers for the variable delay line: width derivation and channel slicing.
package var_delay_pkg;

  // Ceiling log2, with clog2(1) = 0; usable in parameter expressions.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Width of a field that must hold every delay value 0..depth inclusive.
  function automatic int delay_width(input int depth);
    return clog2(depth + 1);
  endfunction

  // Low bit index of channel c in a packed multi-channel bus.
  function automatic int ch_lo(input int c, input int data_width);
    return c * data_width;
  endfunction

endpackage

// File: rtl/var_delay_chan.sv
// One channel of the delay line: DEPTH data stages and the delay-indexed output tap.
module var_delay_chan
  import var_delay_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int DW         = delay_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [DW-1:0]         delay,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic [DATA_WIDTH-1:0] stage [DEPTH];

  // Data shift register: loads on enabled cycles, holds on stall.
  // NOTE: every stage is reset here because a freshly reset line must present
  // zero data at the tap; storage without that requirement would skip reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (en) begin
      // NOTE: non-blocking assignments let every stage sample its neighbour's
      // old value, so the loop order does not matter.
      stage[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  // Output tap: D = 0 passes the input straight through, otherwise stage[D-1].
  always_comb begin
    // NOTE: the default assignment first keeps this block free of latches.
    out_data = in_data;
    for (int i = 0; i < DEPTH; i++) begin
      if (delay == DW'(i + 1)) out_data = stage[i];
    end
  end

endmodule

// File: rtl/var_delay_line.sv
// Multi-channel runtime-programmable delay line with valid tracking, stall,
// flush, post-change output blanking and an out-of-range delay error pulse.
module var_delay_line
  import var_delay_pkg::*;
#(
  parameter int  DATA_WIDTH    = 8,
  parameter int  NUM_CH        = 2,
  parameter int  DEPTH         = 16,
  parameter int  DEFAULT_DELAY = 4,
  parameter bit  CHANGE_BLANK  = 1'b1,
  localparam int DW            = delay_width(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  input  logic                         delay_ld,
  input  logic [DW-1:0]                delay_sel,
  output logic [DW-1:0]                delay_cur,
  output logic                         out_valid,
  output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
  output logic                         blanking,
  output logic                         dly_err
);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_shift;
  logic [DW-1:0]    delay_q;
  logic [DW-1:0]    blank_cnt;
  logic [DW-1:0]    delay_new;
  logic             sel_over;
  logic             tap_v;

  assign sel_over  = delay_sel > DW'(DEPTH);
  assign delay_new = sel_over ? DW'(DEPTH) : delay_sel;

  // Shifted valid chain; flush kills every bit including the incoming one.
  always_comb begin
    v_shift[0] = in_valid & ~flush;
    for (int i = 1; i < DEPTH; i++) v_shift[i] = v_q[i-1] & ~flush;
  end

  // Valid chain register: shifts when enabled, otherwise holds unless flushed.
  always_ff @(posedge clk) begin
    if (rst)        v_q <= '0;
    else if (en)    v_q <= v_shift;
    else if (flush) v_q <= '0;
  end

  // Active delay register and the one-cycle out-of-range error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      delay_q <= DW'(DEFAULT_DELAY);
      dly_err <= 1'b0;
    end else begin
      if (delay_ld) delay_q <= delay_new;
      dly_err <= delay_ld & sel_over;
    end
  end

  // Blank counter: restarts at the new delay on a load, counts enabled cycles down.
  always_ff @(posedge clk) begin
    if (rst || !CHANGE_BLANK)        blank_cnt <= '0;
    else if (delay_ld)               blank_cnt <= delay_new;
    else if (en && blank_cnt != '0)  blank_cnt <= blank_cnt - DW'(1);
  end

  // Valid tap at D-1, mirroring the data tap in each channel.
  always_comb begin
    tap_v = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (delay_q == DW'(i + 1)) tap_v = v_q[i];
    end
  end

  assign blanking  = blank_cnt != '0;
  assign delay_cur = delay_q;
  assign out_valid = (delay_q == '0) ? (in_valid & en & ~flush & ~blanking)
                                     : (tap_v & ~blanking);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    var_delay_chan #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .DW         (DW)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .in_data  (in_data[ch_lo(c, DATA_WIDTH) +: DATA_WIDTH]),
      .delay    (delay_q),
      .out_data (out_data[ch_lo(c, DATA_WIDTH) +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_var_delay_line.sv
// Scoreboard bench for var_delay_line: a history-based reference model predicts
// each cycle's outputs, a monitor compares them on the falling edge.
module tb_var_delay_line;

  localparam int DATA_WIDTH    = 8;
  localparam int NUM_CH        = 2;
  localparam int DEPTH         = 8;
  localparam int DEFAULT_DELAY = 4;
  localparam int DW            = 4;
  localparam int W             = NUM_CH * DATA_WIDTH;

  logic          clk = 1'b0;
  logic          rst, en, flush, in_valid, delay_ld;
  logic [W-1:0]  in_data;
  logic [DW-1:0] delay_sel;
  logic [DW-1:0] delay_cur;
  logic          out_valid, blanking, dly_err;
  logic [W-1:0]  out_data;

  always #5 clk = ~clk;

  var_delay_line #(
    .DATA_WIDTH    (DATA_WIDTH),
    .NUM_CH        (NUM_CH),
    .DEPTH         (DEPTH),
    .DEFAULT_DELAY (DEFAULT_DELAY),
    .CHANGE_BLANK  (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .delay_ld  (delay_ld),
    .delay_sel (delay_sel),
    .delay_cur (delay_cur),
    .out_valid (out_valid),
    .out_data  (out_data),
    .blanking  (blanking),
    .dly_err   (dly_err)
  );

  typedef struct packed {
    logic         v;
    logic [W-1:0] d;
  } sample_t;

  typedef struct packed {
    logic          v;
    logic [W-1:0]  d;
    logic [DW-1:0] dcur;
    logic          blank;
    logic          err;
  } exp_t;

  // Reference model: newest-first history of accepted samples, the active
  // delay, the remaining blanked shifts and the pending error pulse.
  sample_t hist [$];
  int      m_delay;
  int      m_blank;
  bit      m_err;
  exp_t    sb [$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < DEPTH; i++) hist.push_back('0);
    m_delay = DEFAULT_DELAY;
    m_blank = 0;
    m_err   = 1'b0;
  endtask

  // Drive one cycle of inputs, predict its outputs, then advance the model.
  task automatic cycle(input bit r, input bit e, input bit f, input bit iv,
                       input logic [W-1:0] d, input bit ld, input int sel);
    exp_t x;
    int   nd;
    rst = r; en = e; flush = f; in_valid = iv; in_data = d;
    delay_ld = ld; delay_sel = DW'(sel);

    x.blank = (m_blank != 0);
    x.dcur  = DW'(m_delay);
    x.err   = m_err;
    if (m_delay >= 1) begin
      x.d = hist[m_delay-1].d;
      x.v = hist[m_delay-1].v & ~x.blank;
    end else begin
      x.d = d;
      x.v = iv & e & ~f & ~x.blank;
    end
    sb.push_back(x);

    if (r) begin
      model_reset();
    end else begin
      if (e) begin
        hist.push_front('{v: iv & ~f, d: d});
        void'(hist.pop_back());
      end
      if (f) foreach (hist[i]) hist[i].v = 1'b0;
      nd = (sel > DEPTH) ? DEPTH : sel;
      if (ld) m_blank = nd;
      else if (e && m_blank > 0) m_blank--;
      m_err = ld && (sel > DEPTH);
      if (ld) m_delay = nd;
    end

    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle the DUT presents a response, pop and compare it.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        x = sb.pop_front();
        check("out_valid", 32'(out_valid), 32'(x.v));
        check("out_data",  32'(out_data),  32'(x.d));
        check("delay_cur", 32'(delay_cur), 32'(x.dcur));
        check("blanking",  32'(blanking),  32'(x.blank));
        check("dly_err",   32'(dly_err),   32'(x.err));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

  function automatic logic [W-1:0] seq(input int n);
    return {8'(8'h80 + n), 8'(n)};
  endfunction

  initial begin
    int n;
    rst = 1'b1; en = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_data = '0; delay_ld = 1'b0; delay_sel = '0;
    model_reset();
    @(posedge clk);
    #1;

    // Reset state, then a counting stream at the default delay.
    cycle(1, 0, 0, 0, '0, 0, 0);
    n = 1;
    repeat (10) begin cycle(0, 1, 0, 1, seq(n), 0, 0); n++; end

    // Stall mid-stream, then resume.
    repeat (3) cycle(0, 0, 0, 1, 16'hdead, 0, 0);
    repeat (6) begin cycle(0, 1, 0, 1, seq(n), 0, 0); n++; end

    // Load delay 6 with continuous enable and watch the blanking window.
    cycle(0, 1, 0, 1, seq(n), 1, 6); n++;
    repeat (10) begin cycle(0, 1, 0, 1, seq(n), 0, 0); n++; end

    // Out-of-range request clamps to DEPTH and pulses dly_err.
    cycle(0, 1, 0, 1, seq(n), 1, 12); n++;
    repeat (10) begin cycle(0, 1, 0, 1, seq(n), 0, 0); n++; end

    // Zero delay: pass-through, no blanking, including a stalled cycle.
    cycle(0, 1, 0, 1, seq(n), 1, 0); n++;
    repeat (3) begin cycle(0, 1, 0, 1, seq(n), 0, 0); n++; end
    cycle(0, 0, 0, 1, seq(n), 0, 0);
    cycle(0, 1, 1, 1, seq(n), 0, 0); n++;

    // Back to delay 4, then flush mid-stream.
    cycle(0, 1, 0, 1, seq(n), 1, 4); n++;
    repeat (8) begin cycle(0, 1, 0, 1, seq(n), 0, 0); n++; end
    cycle(0, 1, 1, 1, seq(n), 0, 0); n++;
    repeat (8) begin cycle(0, 1, 0, 1, seq(n), 0, 0); n++; end
    // Flush during a stall, and en+flush+load on the same edge.
    cycle(0, 0, 1, 1, seq(n), 0, 0);
    repeat (5) begin cycle(0, 1, 0, 1, seq(n), 0, 0); n++; end
    cycle(0, 1, 1, 1, seq(n), 1, 3); n++;
    repeat (6) begin cycle(0, 1, 0, 1, seq(n), 0, 0); n++; end

    // Reset while blanking with a full pipeline.
    cycle(0, 1, 0, 1, seq(n), 1, 7); n++;
    repeat (2) begin cycle(0, 1, 0, 1, seq(n), 0, 0); n++; end
    cycle(1, 1, 0, 1, seq(n), 0, 0); n++;
    repeat (6) begin cycle(0, 1, 0, 1, seq(n), 0, 0); n++; end

    // Randomised traffic.
    repeat (600) begin
      cycle($urandom_range(0, 99) == 0,
            $urandom_range(0, 9) != 0,
            $urandom_range(0, 19) == 0,
            $urandom_range(0, 9) < 7,
            W'($urandom),
            $urandom_range(0, 14) == 0,
            int'($urandom_range(0, 15)));
    end

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
